// File: rtl/wb_sram_pkg.sv
// Shared types and widths for the Wishbone SRAM slave and its byte-merge helper.
package wb_sram_pkg;

  localparam int RAM_AW = 20;
  localparam int DW     = 32;
  localparam int SELW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RMW_RD   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_ACK      = 3'd6
  } state_e;

  function automatic logic is_ram_state(input state_e s);
    return (s == ST_RD) || (s == ST_RMW_RD) || (s == ST_WR_SETUP) ||
           (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

  function automatic logic is_read_state(input state_e s);
    return (s == ST_RD) || (s == ST_RMW_RD);
  endfunction

  function automatic logic is_drive_state(input state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge: takes new_i bytes where sel_i is set, old_i bytes elsewhere.
module wb_byte_merge
  import wb_sram_pkg::*;
(
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   new_i,
  input  logic [SELW-1:0] sel_i,
  output logic [DW-1:0]   merged_o
);

  // Per-lane select between stored and incoming byte.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < SELW; i++) begin
      if (sel_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end else begin
        merged_o[8*i +: 8] = old_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave for a 32-bit asynchronous SRAM; sub-word stores use read-modify-write.
module wb_sram_slave
  import wb_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_LSB    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wishbone_addr_i,
  input  logic [DW-1:0]     wishbone_data_i,
  input  logic              wishbone_we_i,
  input  logic [SELW-1:0]   wishbone_select_i,
  input  logic              wishbone_stb_i,
  input  logic              wishbone_cyc_i,
  output logic [DW-1:0]     wishbone_data_o,
  output logic              wishbone_ack_o,
  output logic [RAM_AW-1:0] ram_addr,
  inout  wire  [DW-1:0]     ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RAM_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [SELW-1:0]   sel_q;
  logic [DW-1:0]     rdata_q;
  logic              ack_q;
  logic              ce_n_q, oe_n_q, we_n_q, drive_q;

  logic              accept_s;
  logic              rd_last_s;
  logic              rmw_last_s;
  logic [DW-1:0]     merged_s;
  logic              addr_unused_s;

  assign accept_s      = (state_q == ST_IDLE) && wishbone_stb_i && wishbone_cyc_i;
  assign rd_last_s     = (state_q == ST_RD) && (cnt_q == 4'd0);
  assign rmw_last_s    = (state_q == ST_RMW_RD) && (cnt_q == 4'd0);
  assign addr_unused_s = ^wishbone_addr_i;

  wb_byte_merge u_merge (
    .old_i    (ram_data),
    .new_i    (wdata_q),
    .sel_i    (sel_q),
    .merged_o (merged_s)
  );

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (!wishbone_we_i) begin
            state_d = ST_RD;
            cnt_d   = CNT_LOAD;
          end else if (wishbone_select_i == 4'b0000) begin
            state_d = ST_ACK;
          end else if (wishbone_select_i == 4'b1111) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RMW_RD;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RMW_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WR_SETUP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WR_HOLD: state_d = ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, counter and SRAM strobes; strobes are registered from the next state
  // so they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= !is_ram_state(state_d);
      oe_n_q  <= !is_read_state(state_d);
      we_n_q  <= (state_d != ST_WR_PULSE);
      drive_q <= is_drive_state(state_d);
      ack_q   <= (state_q == ST_ACK) && wishbone_cyc_i;
    end
  end

  // Request capture, RMW merge and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 4'b0000;
      rdata_q <= '0;
    end else begin
      if (accept_s) begin
        addr_q  <= wishbone_addr_i[ADDR_LSB +: RAM_AW];
        wdata_q <= wishbone_data_i;
        sel_q   <= wishbone_select_i;
      end else if (rmw_last_s) begin
        wdata_q <= merged_s;
      end
      if (rd_last_s) begin
        rdata_q <= ram_data;
      end
    end
  end

  assign ram_data        = drive_q ? wdata_q : {DW{1'bz}};
  assign ram_addr        = addr_q;
  assign ram_ce_n        = ce_n_q;
  assign ram_oe_n        = oe_n_q;
  assign ram_we_n        = we_n_q;
  assign wishbone_ack_o  = ack_q;
  assign wishbone_data_o = rdata_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave with a behavioural asynchronous SRAM model.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdat_i = 32'd0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'd0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic [31:0] data_o;
  logic        ack_o;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  logic        mem_init = 1'b1;
  logic        probe = 1'b0;
  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail = 0;

  wb_sram_slave #(.WAIT_CYCLES(2), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .wishbone_addr_i(addr_i), .wishbone_data_i(wdat_i), .wishbone_we_i(we_i),
    .wishbone_select_i(sel_i), .wishbone_stb_i(stb_i), .wishbone_cyc_i(cyc_i),
    .wishbone_data_o(data_o), .wishbone_ack_o(ack_o),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hAABBCCDD;
    else if (i == 4) return 32'hDEADBEEF;
    else if (i == 255) return 32'h0BADF00D;
    else return {24'h5A5A5A, 8'(i)};
  endfunction

  // SRAM model: drives on ce&oe, probe drives zero to detect a released bus.
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] :
                    (probe ? 32'h0000_0000 : {32{1'bz}});

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (!ram_ce_n && !ram_we_n) begin
      mem[ram_addr[7:0]] <= ram_data;
    end
  end

  always @(negedge clk) begin
    if (!ram_oe_n || !ram_we_n) begin
      n_checks++;
      if (!ram_oe_n && !ram_we_n) begin
        n_fail++;
        $display("FAIL strobe_overlap: oe_n=%b we_n=%b required not both low", ram_oe_n, ram_we_n);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] dout;
    logic [19:0] waddr;
    int          oe;
    int          wen;
    int          ce;
    logic [31:0] mem_exp;
  } vec_t;

  int          r_lat, r_oe, r_we, r_ce, r_acks;
  logic [19:0] r_addr;
  logic [31:0] r_dout;

  task automatic sample(input int k);
    if (!ram_oe_n) r_oe++;
    if (!ram_we_n) r_we++;
    if (!ram_ce_n) begin
      if (r_ce == 0) r_addr = ram_addr;
      r_ce++;
    end
    if (ack_o) begin
      r_acks++;
      if (r_lat < 0) begin
        r_lat = k;
        r_dout = data_o;
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    we_i = we; addr_i = a; wdat_i = d; sel_i = s; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    r_lat = -1; r_oe = 0; r_we = 0; r_ce = 0; r_acks = 0; r_addr = 20'd0; r_dout = 32'd0;
    sample(0);
    for (int k = 1; k < 40; k++) begin
      if (r_lat >= 0 && k > r_lat + 2) break;
      @(posedge clk);
      #1;
      sample(k);
    end
    cyc_i = 1'b0;
  endtask

  vec_t vecs [10];
  int   mask;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'hDEADBEEF, 20'h00004, 2, 0, 2, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 5, 32'hDEADBEEF, 20'h00008, 0, 2, 4, 32'h12345678};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h00000011, 4'h1, 7, 32'hDEADBEEF, 20'h00000, 2, 2, 6, 32'hAABBCC11};
    vecs[3] = '{1'b1, 32'h0000_0030, 32'hFFFFFFFF, 4'h0, 1, 32'hDEADBEEF, 20'h0000C, 0, 0, 0, 32'h5A5A5A0C};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 3, 32'h12345678, 20'h00008, 2, 0, 2, 32'h12345678};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h99887766, 4'hA, 7, 32'h12345678, 20'h00000, 2, 2, 6, 32'h99BB7711};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, 3, 32'h99BB7711, 20'h00000, 2, 0, 2, 32'h99BB7711};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 3, 32'h0BADF00D, 20'hFFFFF, 2, 0, 2, 32'h0BADF00D};
    vecs[8] = '{1'b1, 32'hFFFF_FFFC, 32'h55660000, 4'hC, 7, 32'h0BADF00D, 20'hFFFFF, 2, 2, 6, 32'h5566F00D};
    vecs[9] = '{1'b0, 32'h0040_0010, 32'h0, 4'hF, 3, 32'hDEADBEEF, 20'h00004, 2, 0, 2, 32'hDEADBEEF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_ram_addr", {12'd0, ram_addr}, 32'd0);
    chk("rst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    probe = 1'b1;
    #1;
    chk("rst_ram_data_released", ram_data, 32'h0000_0000);
    probe = 1'b0;
    rst = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel);
      chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_ack_count", i), 32'(r_acks), 32'd1);
      chk($sformatf("v%0d_data_o", i), r_dout, vecs[i].dout);
      chk($sformatf("v%0d_oe_cycles", i), 32'(r_oe), 32'(vecs[i].oe));
      chk($sformatf("v%0d_we_cycles", i), 32'(r_we), 32'(vecs[i].wen));
      chk($sformatf("v%0d_ce_cycles", i), 32'(r_ce), 32'(vecs[i].ce));
      if (vecs[i].ce > 0) chk($sformatf("v%0d_ram_addr", i), {12'd0, r_addr}, {12'd0, vecs[i].waddr});
      chk($sformatf("v%0d_mem_word", i), mem[vecs[i].waddr[7:0]], vecs[i].mem_exp);
    end

    // Reset asserted while the write pulse is active.
    @(negedge clk);
    we_i = 1'b1; addr_i = 32'h0000_0050; wdat_i = 32'hCAFEF00D; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_in_pulse_we_n", {31'd0, ram_we_n}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstw_we_n", {31'd0, ram_we_n}, 32'd1);
    chk("rstw_ce_n", {31'd0, ram_ce_n}, 32'd1);
    chk("rstw_ack", {31'd0, ack_o}, 32'd0);
    chk("rstw_data_o", data_o, 32'd0);
    probe = 1'b1;
    #1;
    chk("rstw_ram_data_released", ram_data, 32'h0000_0000);
    probe = 1'b0;
    rst = 1'b0;
    r_acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (ack_o) r_acks++;
    end
    cyc_i = 1'b0;
    chk("rstw_no_ack", 32'(r_acks), 32'd0);
    run_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    chk("rstw_read_latency", 32'(r_lat), 32'd3);
    chk("rstw_read_data", r_dout, 32'hDEADBEEF);

    // cyc_i dropped during a read: access completes, no ack.
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h0000_0020; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk);
    #1;
    stb_i = 1'b0; cyc_i = 1'b0;
    r_lat = -1; r_oe = 0; r_we = 0; r_ce = 0; r_acks = 0;
    sample(0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      #1;
      sample(k);
    end
    chk("cycdrop_no_ack", 32'(r_acks), 32'd0);
    chk("cycdrop_oe_cycles", 32'(r_oe), 32'd2);

    // Back-to-back reads with the request held: acks at T+3 and T+7.
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h0000_0020; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk);
    mask = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (ack_o) begin
        mask = mask | (1 << k);
        chk($sformatf("b2b_data_k%0d", k), data_o, 32'h12345678);
      end
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    chk("b2b_ack_pattern", 32'(mask), 32'h0000_0088);
    repeat (8) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
